// File: rtl/mxu_sequencer_if.sv
// Signal bundle between mxu_sequencer and its surroundings: executor handshake,
// scratchpad read/write port and the systolic array drive.
interface mxu_sequencer_if #(
   parameter int NUM_SIZE  = 16,
   parameter int GRID_SIZE = 2,
   parameter int ADDR_W    = 5
);
   logic                                    start;
   logic [ADDR_W-1:0]                       a_addr;
   logic [ADDR_W-1:0]                       b_addr;
   logic [ADDR_W-1:0]                       c_addr;
   logic                                    busy;
   logic                                    done;
   logic [ADDR_W-1:0]                       mem_raddr;
   logic [NUM_SIZE-1:0]                     mem_rdata;
   logic                                    mem_we;
   logic [ADDR_W-1:0]                       mem_waddr;
   logic [NUM_SIZE-1:0]                     mem_wdata;
   logic                                    mxu_ce;
   logic                                    mxu_clear;
   logic [NUM_SIZE*GRID_SIZE-1:0]           north_input;
   logic [NUM_SIZE*GRID_SIZE-1:0]           west_input;
   logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] result_in;

   // The sequencer's own view.
   modport master (
      input  start, a_addr, b_addr, c_addr, mem_rdata, result_in,
      output busy, done, mem_raddr, mem_we, mem_waddr, mem_wdata,
             mxu_ce, mxu_clear, north_input, west_input
   );

   // The executor / scratchpad / array side.
   modport slave (
      output start, a_addr, b_addr, c_addr, mem_rdata, result_in,
      input  busy, done, mem_raddr, mem_we, mem_waddr, mem_wdata,
             mxu_ce, mxu_clear, north_input, west_input
   );
endinterface

// File: rtl/mxu_sequencer.sv
// Runs one 2x2 matrix multiply on the systolic MXU: load A/B from the scratchpad,
// feed them with diagonal skew, drain, and write C back.
module mxu_sequencer #(
   parameter int NUM_SIZE     = 16,
   parameter int GRID_SIZE    = 2,
   parameter int ADDR_W       = 5,
   parameter int DRAIN_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   mxu_sequencer_if.master bus
);
   localparam int LANES = GRID_SIZE * GRID_SIZE;
   localparam int CNT_W = (DRAIN_CYCLES > 8) ? $clog2(DRAIN_CYCLES) : 3;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CLEAR, S_FEED, S_DRAIN, S_WRITE, S_DONE
   } state_t;

   state_t              state, state_next;
   logic [CNT_W-1:0]    cnt, cnt_next;
   logic                last;
   logic [ADDR_W-1:0]   a_base, b_base, c_base;
   logic [ADDR_W-1:0]   offset;
   logic [NUM_SIZE-1:0] a_op [LANES];
   logic [NUM_SIZE-1:0] b_op [LANES];

   assign offset = ADDR_W'(cnt[1:0]);

   // NOTE: all state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         a_base <= '0;
         b_base <= '0;
         c_base <= '0;
         // NOTE: the operands are a handful of flops, not a RAM, so they take the reset too.
         for (int k = 0; k < LANES; k++) begin
            a_op[k] <= '0;
            b_op[k] <= '0;
         end
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (state == S_IDLE && bus.start) begin
            a_base <= bus.a_addr;
            b_base <= bus.b_addr;
            c_base <= bus.c_addr;
         end
         if (state == S_LOAD) begin
            if (cnt[2]) b_op[cnt[1:0]] <= bus.mem_rdata;
            else        a_op[cnt[1:0]] <= bus.mem_rdata;
         end
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_next      = state;
      last            = 1'b0;
      bus.busy        = (state != S_IDLE);
      bus.done        = 1'b0;
      bus.mem_raddr   = '0;
      bus.mem_we      = 1'b0;
      bus.mem_waddr   = '0;
      bus.mem_wdata   = '0;
      bus.mxu_ce      = 1'b0;
      bus.mxu_clear   = 1'b0;
      bus.north_input = '0;
      bus.west_input  = '0;

      case (state)
         S_IDLE: if (bus.start) state_next = S_LOAD;
         S_LOAD: begin
            bus.mem_raddr = (cnt[2] ? b_base : a_base) + offset;
            last = (cnt == CNT_W'(7));
            if (last) state_next = S_CLEAR;
         end
         S_CLEAR: begin
            bus.mxu_clear = 1'b1;
            last          = 1'b1;
            state_next    = S_FEED;
         end
         S_FEED: begin
            bus.mxu_ce = 1'b1;
            // Lane 0 is the low half; row i / column j is delayed by i / j steps.
            case (cnt[1:0])
               2'd0: begin
                  bus.west_input  = {{NUM_SIZE{1'b0}}, a_op[0]};
                  bus.north_input = {{NUM_SIZE{1'b0}}, b_op[0]};
               end
               2'd1: begin
                  bus.west_input  = {a_op[2], a_op[1]};
                  bus.north_input = {b_op[1], b_op[2]};
               end
               2'd2: begin
                  bus.west_input  = {a_op[3], {NUM_SIZE{1'b0}}};
                  bus.north_input = {b_op[3], {NUM_SIZE{1'b0}}};
               end
               default: ;
            endcase
            last = (cnt == CNT_W'(3));
            if (last) state_next = S_DRAIN;
         end
         S_DRAIN: begin
            bus.mxu_ce = 1'b1;
            last = (cnt == CNT_W'(DRAIN_CYCLES - 1));
            if (last) state_next = S_WRITE;
         end
         S_WRITE: begin
            bus.mem_we    = 1'b1;
            bus.mem_waddr = c_base + offset;
            case (cnt[1:0])
               2'd0:    bus.mem_wdata = bus.result_in[0*NUM_SIZE +: NUM_SIZE];
               2'd1:    bus.mem_wdata = bus.result_in[1*NUM_SIZE +: NUM_SIZE];
               2'd2:    bus.mem_wdata = bus.result_in[2*NUM_SIZE +: NUM_SIZE];
               default: bus.mem_wdata = bus.result_in[3*NUM_SIZE +: NUM_SIZE];
            endcase
            last = (cnt == CNT_W'(3));
            if (last) state_next = S_DONE;
         end
         S_DONE: begin
            bus.done   = 1'b1;
            last       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase

      cnt_next = (state == S_IDLE || last) ? '0 : cnt + CNT_W'(1);
   end
endmodule

// File: tb/tb_mxu_sequencer.sv
// Bench for mxu_sequencer: scratchpad and 2x2 systolic array models around the DUT,
// expected C from plain matrix arithmetic, cycle-by-cycle timing checks.
module tb_mxu_sequencer;
   localparam int NS = 16;
   localparam int GS = 2;
   localparam int AW = 5;
   localparam int DC = 1;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   mxu_sequencer_if #(.NUM_SIZE(NS), .GRID_SIZE(GS), .ADDR_W(AW)) bus ();

   mxu_sequencer #(.NUM_SIZE(NS), .GRID_SIZE(GS), .ADDR_W(AW), .DRAIN_CYCLES(DC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Scratchpad: combinational read, write on the clock edge.
   logic [15:0] mem [32];
   assign bus.mem_rdata = mem[bus.mem_raddr];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_waddr] = bus.mem_wdata;

   // Output-stationary 2x2 array: operands move east/south one PE per enabled cycle.
   logic [15:0] acc [4];
   logic [15:0] a_pass [2];
   logic [15:0] b_pass [2];
   logic [15:0] w0, w1, n0, n1;
   assign w0 = bus.west_input[15:0];
   assign w1 = bus.west_input[31:16];
   assign n0 = bus.north_input[15:0];
   assign n1 = bus.north_input[31:16];
   assign bus.result_in = {acc[3], acc[2], acc[1], acc[0]};

   always @(posedge clk) begin
      if (bus.mxu_clear) begin
         for (int k = 0; k < 4; k++) acc[k] <= '0;
         for (int k = 0; k < 2; k++) begin
            a_pass[k] <= '0;
            b_pass[k] <= '0;
         end
      end else if (bus.mxu_ce) begin
         acc[0]    <= acc[0] + w0 * n0;
         acc[1]    <= acc[1] + a_pass[0] * n1;
         acc[2]    <= acc[2] + w1 * b_pass[0];
         acc[3]    <= acc[3] + a_pass[1] * b_pass[1];
         a_pass[0] <= w0;
         a_pass[1] <= w1;
         b_pass[0] <= n0;
         b_pass[1] <= n1;
      end
   end

   logic [15:0] mat_a [4];
   logic [15:0] mat_b [4];
   logic [15:0] ea [4];
   logic [15:0] eb [4];
   logic [15:0] ec [4];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " busy"}, bus.busy, 0);
      check({tag, " done"}, bus.done, 0);
      check({tag, " we"}, bus.mem_we, 0);
      check({tag, " ce"}, bus.mxu_ce, 0);
      check({tag, " clear"}, bus.mxu_clear, 0);
      check({tag, " raddr"}, bus.mem_raddr, 0);
      check({tag, " waddr"}, bus.mem_waddr, 0);
      check({tag, " wdata"}, bus.mem_wdata, 0);
      check({tag, " north"}, bus.north_input, 0);
      check({tag, " west"}, bus.west_input, 0);
   endtask

   task automatic put_mats(input int a, input int b);
      for (int n = 0; n < 4; n++) mem[5'((a + n) % 32)] = mat_a[n];
      for (int n = 0; n < 4; n++) mem[5'((b + n) % 32)] = mat_b[n];
   endtask

   task automatic rand_mats();
      for (int n = 0; n < 4; n++) begin
         mat_a[n] = 16'($urandom);
         mat_b[n] = 16'($urandom);
      end
   endtask

   // Entered and left at a negedge with the DUT idle; start is sampled at the next edge.
   task automatic run_op(input int a, input int b, input int cb, input int extra_start,
                         input int abort_at);
      logic [15:0] c_before [4];
      logic [15:0] wl [2];
      logic [15:0] nl [2];
      longint      s;
      int          t, d;
      for (int n = 0; n < 4; n++) begin
         ea[n]       = mem[5'((a + n) % 32)];
         eb[n]       = mem[5'((b + n) % 32)];
         c_before[n] = mem[5'((cb + n) % 32)];
      end
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            s = 0;
            for (int k = 0; k < 2; k++)
               s += longint'($signed(ea[i*2+k])) * longint'($signed(eb[k*2+j]));
            ec[i*2+j] = 16'(s);
         end

      bus.a_addr = 5'(a);
      bus.b_addr = 5'(b);
      bus.c_addr = 5'(cb);
      bus.start  = 1'b1;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         if (c == extra_start) begin
            bus.start  = 1'b1;
            bus.a_addr = 5'(a + 7);
            bus.b_addr = 5'(b + 3);
            bus.c_addr = 5'(cb + 1);
         end
         if (c == extra_start + 1) bus.start = 1'b0;
         if (c == abort_at) begin
            rst = 1'b1;
            #1 check_quiet($sformatf("abort c%0d", c));
            repeat (3) begin
               @(negedge clk);
               check("abort hold we", bus.mem_we, 0);
               check("abort hold busy", bus.busy, 0);
            end
            rst = 1'b0;
            @(negedge clk);
            for (int w = 0; w < 4; w++)
               check($sformatf("abort c%0d untouched", w), mem[5'((cb + w) % 32)], c_before[w]);
            return;
         end

         check($sformatf("c%0d busy", c), bus.busy, 1);
         check($sformatf("c%0d done", c), bus.done, c == 19);
         check($sformatf("c%0d clear", c), bus.mxu_clear, c == 9);
         check($sformatf("c%0d ce", c), bus.mxu_ce, c >= 10 && c <= 14);
         check($sformatf("c%0d we", c), bus.mem_we, c >= 15 && c <= 18);
         if (c <= 8)
            check($sformatf("c%0d raddr", c), bus.mem_raddr,
                  (c <= 4) ? (a + c - 1) % 32 : (b + c - 5) % 32);
         if (c >= 10 && c <= 14) begin
            t = c - 10;
            for (int i = 0; i < 2; i++) begin
               d = t - i;
               if (d >= 0 && d <= 1) wl[i] = ea[i*2+d];
               else                  wl[i] = 16'd0;
               if (d >= 0 && d <= 1) nl[i] = eb[d*2+i];
               else                  nl[i] = 16'd0;
            end
            check($sformatf("c%0d west", c), bus.west_input, {wl[1], wl[0]});
            check($sformatf("c%0d north", c), bus.north_input, {nl[1], nl[0]});
         end else begin
            check($sformatf("c%0d west idle", c), bus.west_input, 0);
            check($sformatf("c%0d north idle", c), bus.north_input, 0);
         end
         if (c >= 15 && c <= 18) begin
            check($sformatf("c%0d waddr", c), bus.mem_waddr, (cb + c - 15) % 32);
            check($sformatf("c%0d wdata", c), bus.mem_wdata, ec[c-15]);
         end
      end
      @(negedge clk);
      check("c20 busy", bus.busy, 0);
      check("c20 done", bus.done, 0);
      check("c20 we", bus.mem_we, 0);
      for (int w = 0; w < 4; w++)
         check($sformatf("mem C%0d", w), mem[5'((cb + w) % 32)], ec[w]);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.a_addr = '0;
      bus.b_addr = '0;
      bus.c_addr = '0;
      rst        = 1'b0;
      for (int k = 0; k < 32; k++) mem[k] = 16'd0;

      #2 rst = 1'b1;
      #1 check_quiet("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_quiet("idle");

      // Basic product.
      mat_a = '{16'd1, 16'd2, 16'd3, 16'd4};
      mat_b = '{16'd5, 16'd6, 16'd7, 16'd8};
      put_mats(0, 4);
      run_op(0, 4, 8, 0, 0);
      check("basic c00", mem[8], 19);
      check("basic c01", mem[9], 22);
      check("basic c10", mem[10], 43);
      check("basic c11", mem[11], 50);

      // Signed operands.
      mat_a = '{16'hFFFF, 16'd2, 16'd0, 16'd3};
      mat_b = '{16'd4, 16'hFFFB, 16'd6, 16'd7};
      put_mats(12, 16);
      run_op(12, 16, 20, 0, 0);
      check("signed c00", mem[20], 8);
      check("signed c01", mem[21], 19);
      check("signed c10", mem[22], 18);
      check("signed c11", mem[23], 21);

      // Address wrap; C overwrites A.
      rand_mats();
      put_mats(30, 4);
      run_op(30, 4, 30, 0, 0);

      // Start while busy, then a back-to-back run launched in cycle 20.
      rand_mats();
      put_mats(2, 10);
      run_op(2, 10, 20, 5, 0);
      rand_mats();
      put_mats(6, 14);
      run_op(6, 14, 24, 0, 0);

      // Reset in the middle of FEED, then a fresh run.
      rand_mats();
      put_mats(0, 8);
      run_op(0, 8, 16, 0, 11);
      check_quiet("after abort");
      rand_mats();
      put_mats(0, 8);
      run_op(0, 8, 16, 0, 0);

      // Random operands and placements.
      repeat (6) begin
         int a, b, cb;
         a  = int'($urandom_range(0, 31));
         b  = int'($urandom_range(0, 31));
         cb = int'($urandom_range(0, 31));
         rand_mats();
         put_mats(a, b);
         run_op(a, b, cb, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mxu_sequencer.md
# mxu_sequencer

Controller that runs one 2x2 matrix multiply on the systolic MXU, triggered by a single `start` pulse. It reads operand matrices A and B from the scratchpad, feeds them into the array with the diagonal skew the array requires, and drains it. It then writes C = A·B back to the scratchpad and pulses `done`. It replaces hand-placed buffer loads in the instruction executor, which only issues `start` and waits for `done`.

## Interface
- `NUM_SIZE`, 16, element width in bits (signed two's complement)
- `GRID_SIZE`, 2, array dimension; only 2 is supported
- `ADDR_W`, 5, scratchpad address width
- `DRAIN_CYCLES`, 1, extra `ce` cycles with zero inputs after feeding

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin an operation; sampled only in IDLE
- `a_addr`, `b_addr`, `c_addr`  in  ADDR_W each  base addresses of A, B and C; each matrix is 4 words, row-major
- `busy`  out  1  high from the cycle after `start` is accepted through the `done` cycle
- `done`  out  1  one-cycle pulse when C has been written
- `mem_raddr`  out  ADDR_W  scratchpad read address; combinational read, so `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  NUM_SIZE  read data
- `mem_we`  out  1  scratchpad write enable
- `mem_waddr`  out  ADDR_W  write address
- `mem_wdata`  out  NUM_SIZE  write data
- `mxu_ce`  out  1  array clock enable
- `mxu_clear`  out  1  synchronous clear of the array accumulators and pipeline registers
- `north_input`, `west_input`  out  NUM_SIZE*GRID_SIZE each  column j / row i operands; lane k occupies bits [(k+1)*NUM_SIZE-1 : k*NUM_SIZE]
- `result_in`  in  NUM_SIZE*4  accumulators from the MXU; PE(i,j) is lane i*2+j

## Operation
- FSM states: IDLE → LOAD (8 cycles) → CLEAR (1) → FEED (4) → DRAIN (DRAIN_CYCLES) → WRITE (4) → DONE (1) → IDLE.
- **IDLE**
  - On `start`=1, latch `a_addr`, `b_addr`, `c_addr` and go to LOAD.
  - `start` in any other state is ignored and is not queued.
- **LOAD**
  - Counter n=0..7. `mem_raddr` = (a_addr+n) mod 32 for n<4, else (b_addr+n-4) mod 32.
  - `mem_rdata` is captured into operand register A[n] (n<4) or B[n-4] (n≥4).
  - Addresses wrap modulo 2^ADDR_W.
- **CLEAR**: `mxu_clear`=1 and `mxu_ce`=0 for one cycle.
- **FEED** (`mxu_ce`=1), step t=0..3:
  - West row i drives A[i][t-i] when 0≤t-i≤1, else 0.
  - North column j drives B[t-j][j] when 0≤t-j≤1, else 0.
  - Result: t=0 → W=(A00,0), N=(B00,0); t=1 → W=(A01,A10), N=(B10,B01); t=2 → W=(0,A11), N=(0,B11); t=3 → all 0.
- **DRAIN**: `mxu_ce`=1, all inputs 0, for DRAIN_CYCLES cycles.
- **WRITE**
  - `mxu_ce`=0, so the results hold.
  - Counter w=0..3: `mem_we`=1, `mem_waddr`=(c_addr+w) mod 32, `mem_wdata`=lane w of `result_in`. Order is C00, C01, C10, C11.
- **DONE**: `done`=1 for one cycle, then return to IDLE.
- Arithmetic is done inside the MXU (signed multiply-accumulate, truncated to NUM_SIZE). The sequencer copies result bits unmodified.
- Outputs default to 0 in any state that does not drive them: `mem_we`, `mxu_ce`, `mxu_clear`, operand buses.

## Timing
- All state changes happen on the rising edge of `clk`.
- Outputs are decoded from registered state and counters. `mem_wdata` is a combinational selection of `result_in`.
- Latency: `start` is sampled at edge E0. LOAD occupies cycles 1–8, CLEAR 9, FEED 10–13, DRAIN 14, WRITE 15–18, and `done` is high in cycle 19 (with DRAIN_CYCLES=1).
- Back-to-back: `start` sampled in the cycle after DONE is accepted, so the minimum period is 20 cycles.
- Overlap rule: the write to C in cycle 15+ may overwrite A or B, because all operands were captured during LOAD.
- Reset (asynchronous, any state, including mid-FEED or mid-WRITE):
  - FSM goes to IDLE; counters, latched addresses and operand registers clear to 0.
  - `busy`, `done`, `mem_we`, `mxu_ce`, `mxu_clear` are 0; `mem_raddr`, `mem_waddr`, `mem_wdata`, `north_input`, `west_input` are 0.
  - A partial C write is not completed.

## Test plan
- **Basic product:** A=[1,2;3,4] at 0, B=[5,6;7,8] at 4, c_addr=8, pulse `start` → mem[8..11]=19,22,43,50; `done` in cycle 19; `busy` high for cycles 1–19.
- **Signed values:** A=[-1,2;0,3], B=[4,-5;6,7] → C=8,19,18,21, with 16-bit two's complement on `mem_wdata`.
- **Address wrap:** a_addr=30, so A is read from 30,31,0,1; c_addr=30 → writes land at 30,31,0,1 and `mem_raddr` never exceeds 31.
- **Start while busy:** second `start` pulse at cycle 5 → ignored; exactly one `done`, and a `start` in cycle 20 launches a second run with a correct result.
- **Reset mid-operation:** assert `rst` in cycle 11 (FEED) → all outputs 0 immediately, no `mem_we` afterwards; a fresh `start` after release produces a correct C.
- **Skew check:** monitor `north_input`/`west_input` during cycles 10–14 → exactly the FEED/DRAIN sequence above; `mxu_clear` high only in cycle 9.
